// File: rtl/program_counter.sv
// Hack-style program counter with gate-level flag, jump-condition and incrementer logic.
// Only the pc/taken/halted registers are behavioural; WIDTH must be a multiple of 8.

module gate_nand (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = ~(a & b);
endmodule

module gate_not (
    input  logic a,
    output logic y
);
    gate_nand u_nand (.a(a), .b(a), .y(y));
endmodule

module gate_and (
    input  logic a,
    input  logic b,
    output logic y
);
    logic n_s;
    gate_nand u_nand (.a(a), .b(b), .y(n_s));
    gate_not  u_not  (.a(n_s), .y(y));
endmodule

module gate_or (
    input  logic a,
    input  logic b,
    output logic y
);
    logic na_s;
    logic nb_s;
    gate_not  u_na   (.a(a), .y(na_s));
    gate_not  u_nb   (.a(b), .y(nb_s));
    gate_nand u_nand (.a(na_s), .b(nb_s), .y(y));
endmodule

module gate_xor (
    input  logic a,
    input  logic b,
    output logic y
);
    logic n_ab_s;
    logic n_a_s;
    logic n_b_s;
    gate_nand u_n0 (.a(a), .b(b), .y(n_ab_s));
    gate_nand u_n1 (.a(a), .b(n_ab_s), .y(n_a_s));
    gate_nand u_n2 (.a(b), .b(n_ab_s), .y(n_b_s));
    gate_nand u_n3 (.a(n_a_s), .b(n_b_s), .y(y));
endmodule

module gate_mux (
    input  logic a,
    input  logic b,
    input  logic sel,
    output logic y
);
    logic nsel_s;
    logic pa_s;
    logic pb_s;
    gate_not u_ns (.a(sel), .y(nsel_s));
    gate_and u_pa (.a(a), .b(nsel_s), .y(pa_s));
    gate_and u_pb (.a(b), .b(sel), .y(pb_s));
    gate_or  u_o  (.a(pa_s), .b(pb_s), .y(y));
endmodule

module gate_or8way (
    input  logic [7:0] in,
    output logic       y
);
    logic o01_s;
    logic o23_s;
    logic o45_s;
    logic o67_s;
    logic o03_s;
    logic o47_s;
    gate_or u_o01 (.a(in[0]), .b(in[1]), .y(o01_s));
    gate_or u_o23 (.a(in[2]), .b(in[3]), .y(o23_s));
    gate_or u_o45 (.a(in[4]), .b(in[5]), .y(o45_s));
    gate_or u_o67 (.a(in[6]), .b(in[7]), .y(o67_s));
    gate_or u_o03 (.a(o01_s), .b(o23_s), .y(o03_s));
    gate_or u_o47 (.a(o45_s), .b(o67_s), .y(o47_s));
    gate_or u_o07 (.a(o03_s), .b(o47_s), .y(y));
endmodule

// One Or8Way per byte, then the byte results are chained through Or gates.
module gate_or_reduce #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] in,
    output logic             y
);
    localparam int GROUPS = WIDTH / 8;

    for (genvar g = 0; g < GROUPS; g++) begin : g_grp
        logic grp;
        logic acc;
        gate_or8way u_or8 (.in(in[8*g +: 8]), .y(grp));
        if (g == 0) begin : g_first
            assign acc = grp;
        end else begin : g_chain
            gate_or u_or (.a(g_grp[g-1].acc), .b(grp), .y(acc));
        end
    end

    assign y = g_grp[GROUPS-1].acc;
endmodule

module program_counter #(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] RESET_VEC = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             jump_valid,
    input  logic [2:0]       jmp,
    input  logic [WIDTH-1:0] alu_out,
    input  logic [WIDTH-1:0] a_reg,
    output logic [WIDTH-1:0] pc,
    output logic             zr,
    output logic             ng,
    output logic             taken,
    output logic             halted
);
    logic [WIDTH-1:0] pc_r;
    logic             taken_r;
    logic             halted_r;

    logic             alu_any_s;
    logic             lt_s;
    logic             eq_s;
    logic             gt_s;
    logic             nzr_s;
    logic             nng_s;
    logic             pos_s;
    logic             le_s;
    logic             cond_s;
    logic             take_s;
    logic [WIDTH-1:0] inc_s;
    logic [WIDTH-1:0] pc_next_s;
    logic [WIDTH-1:0] diff_s;
    logic             differ_s;
    logic             same_s;
    logic             self_loop_s;

    gate_or_reduce #(.WIDTH(WIDTH)) u_alu_or (.in(alu_out), .y(alu_any_s));
    gate_not u_zr (.a(alu_any_s), .y(zr));
    assign ng = alu_out[WIDTH-1];

    // gt means strictly positive: neither zero nor negative.
    gate_not u_nzr (.a(zr), .y(nzr_s));
    gate_not u_nng (.a(ng), .y(nng_s));
    gate_and u_pos (.a(nzr_s), .b(nng_s), .y(pos_s));
    gate_and u_lt  (.a(jmp[2]), .b(ng), .y(lt_s));
    gate_and u_eq  (.a(jmp[1]), .b(zr), .y(eq_s));
    gate_and u_gt  (.a(jmp[0]), .b(pos_s), .y(gt_s));
    gate_or  u_le  (.a(lt_s), .b(eq_s), .y(le_s));
    gate_or  u_cnd (.a(le_s), .b(gt_s), .y(cond_s));
    gate_and u_tk  (.a(jump_valid), .b(cond_s), .y(take_s));

    // Ripple incrementer: each bit's carry-in is the AND of all lower pc bits.
    for (genvar i = 0; i < WIDTH; i++) begin : g_inc
        logic cin;
        if (i == 0) begin : g_c0
            assign cin = 1'b1;
        end else begin : g_cn
            gate_and u_c (.a(pc_r[i-1]), .b(g_inc[i-1].cin), .y(cin));
        end
        gate_xor u_s   (.a(pc_r[i]), .b(cin), .y(inc_s[i]));
        gate_mux u_mux (.a(inc_s[i]), .b(a_reg[i]), .sel(take_s), .y(pc_next_s[i]));
        gate_xor u_d   (.a(pc_r[i]), .b(a_reg[i]), .y(diff_s[i]));
    end

    gate_or_reduce #(.WIDTH(WIDTH)) u_diff_or (.in(diff_s), .y(differ_s));
    gate_not u_same (.a(differ_s), .y(same_s));
    gate_and u_self (.a(take_s), .b(same_s), .y(self_loop_s));

    // State registers: reset beats stall, stall beats jump/increment.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_r     <= RESET_VEC;
            taken_r  <= 1'b0;
            halted_r <= 1'b0;
        end else if (en) begin
            pc_r     <= pc_next_s;
            taken_r  <= take_s;
            halted_r <= halted_r | self_loop_s;
        end else begin
            pc_r     <= pc_r;
            taken_r  <= taken_r;
            halted_r <= halted_r;
        end
    end

    assign pc     = pc_r;
    assign taken  = taken_r;
    assign halted = halted_r;
endmodule
